braille_sched: RTL

Character feed scheduler for the braille translator controller. Buffers incoming 7-bit ASCII characters in a small FIFO, adds even parity, and starts the translator with its `G` input. Presents one character per translator `load` request. When the buffer runs dry it parks the translator with a parity-fail stop code. Optionally counts emitted braille cells per line and flags line wrap.

---
 rtl/braille_sched.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/braille_sched.sv
// rtl/braille_sched.sv - character feed scheduler for the braille translator
//
// Buffers 7-bit ASCII characters in a DEPTH-entry FIFO, presents each one to
// the translator with even parity added, and starts the translator with tr_g.
// When the FIFO runs dry the stop code 8'h80 (odd parity) parks the translator.
//
// Optional feature macro: BRAILLE_LINEWRAP_EN enables the column counter
// (col / line_end). Without it both outputs are tied to 0.
//
// Parameters:
//   DEPTH     FIFO depth in characters (power of 2, >= 2)
//   LINE_LEN  cells per output line (2..64)
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-low reset
//   in_valid  upstream character valid
//   in_char   7-bit ASCII character
//   in_ready  FIFO can accept (!full)
//   tr_g      start request to the translator (registered)
//   tr_a      character / stop code to the translator (combinational)
//   tr_load   translator load strobe, samples tr_a this cycle
//   tr_valid  translator valid, one emitted cell per high cycle
//   busy      FSM not idle or FIFO not empty
//   col       current output column
//   line_end  one-cycle pulse after the last cell of a line

module braille_sched #(
    parameter int DEPTH    = 8,
    parameter int LINE_LEN = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [6:0] in_char,
    output logic       in_ready,
    output logic       tr_g,
    output logic [7:0] tr_a,
    input  logic       tr_load,
    input  logic       tr_valid,
    output logic       busy,
    output logic [5:0] col,
    output logic       line_end
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KICK = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [6:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic [6:0]    head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign head     = mem[rptr];

    // Even parity over all 8 bits makes the translator accept the character;
    // the odd-parity stop code sends it back to its idle state.
    assign tr_a = empty ? 8'h80 : {^head, head};

    assign busy = (state != IDLE) || !empty;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= in_char;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            tr_g  <= 1'b0;
        end else begin
            state <= state_nx;
            tr_g  <= (state_nx == KICK);
        end
    end

    // A push landing in the same cycle as the stop-code load only updates
    // the count at the edge, so the stop code still goes out and the new
    // character is picked up by a fresh KICK from IDLE.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nx = KICK;
                end
            end
            KICK: begin
                // Hold G until the translator actually loads; it may still be
                // finishing its previous run.
                if (tr_load) begin
                    pop      = !empty;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (tr_load) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Column counter
    // ------------------------------------------------------------------
`ifdef BRAILLE_LINEWRAP_EN
    localparam logic [5:0] COL_LAST = 6'(LINE_LEN - 1);

    logic [5:0] col_q;
    logic       line_end_q;

    // Not cleared when the FSM idles: a line spans text bursts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q      <= '0;
            line_end_q <= 1'b0;
        end else begin
            line_end_q <= 1'b0;
            if (tr_valid) begin
                if (col_q == COL_LAST) begin
                    col_q      <= '0;
                    line_end_q <= 1'b1;
                end else begin
                    col_q <= col_q + 6'd1;
                end
            end
        end
    end

    assign col      = col_q;
    assign line_end = line_end_q;
`else
    logic unused_tr_valid;

    assign unused_tr_valid = tr_valid;
    assign col             = 6'd0;
    assign line_end        = 1'b0;
`endif

endmodule
